reg_dump_ctrl: RTL and testbench

REG_DUMP_CTRL -- requirements
Module: reg_dump_ctrl

---
 rtl/reg_dump_ctrl.sv | 126 ++++++++++++
 tb/tb_reg_dump_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_ctrl.sv
// Register-bank dump controller: reads each register of a halted core
// and streams it MSB byte first to a byte sink with a valid/ready handshake.
module reg_dump_ctrl #(
   parameter int NB_DATA = 32,
   parameter int NB_REG  = 5,
   parameter int N_REGS  = 32
) (
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic               start_i,
   input  logic               halted_i,
   input  logic [NB_DATA-1:0] data_ra_i,
   input  logic               tx_ready_i,
   output logic               select_debug_o,
   output logic [NB_REG-1:0]  addr_reg_debug_o,
   output logic [7:0]         tx_data_o,
   output logic               tx_valid_o,
   output logic               busy_o,
   output logic               done_o
);

   localparam int NBYTES = NB_DATA / 8;
   localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [CW-1:0]     LAST_BYTE = CW'(NBYTES - 1);
   localparam logic [NB_REG-1:0] LAST_REG  = NB_REG'(N_REGS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LATCH,
      S_SEND,
      S_DONE
   } state_e;

   state_e             state_q, state_d;
   logic [NB_REG-1:0]  index_q, index_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [NB_DATA-1:0] shift_q, shift_d;
   logic               sel_q, sel_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   always_comb begin
      state_d = state_q;
      index_d = index_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_i && halted_i) begin
               state_d = S_LATCH;
               index_d = '0;
            end
         end
         S_LATCH: begin
            if (!halted_i) begin
               state_d = S_IDLE;
            end else begin
               shift_d = data_ra_i;
               cnt_d   = '0;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            // An accepted byte counts even if the dump aborts this cycle
            if (tx_ready_i) begin
               shift_d = shift_q << 8;
               cnt_d   = cnt_q + CW'(1);
            end
            if (!halted_i) begin
               state_d = S_IDLE;
            end else if (tx_ready_i && (cnt_q == LAST_BYTE)) begin
               if (index_q == LAST_REG) begin
                  state_d = S_DONE;
               end else begin
                  index_d = index_q + NB_REG'(1);
                  state_d = S_LATCH;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      sel_d   = (state_d == S_LATCH) || (state_d == S_SEND);
      valid_d = (state_d == S_SEND);
      busy_d  = (state_d != S_IDLE);
      done_d  = (state_d == S_DONE);
   end

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q <= S_IDLE;
         index_q <= '0;
         cnt_q   <= '0;
         shift_q <= '0;
         sel_q   <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         sel_q   <= sel_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign select_debug_o   = sel_q;
   assign addr_reg_debug_o = index_q;
   assign tx_data_o        = shift_q[NB_DATA-1 -: 8];
   assign tx_valid_o       = valid_q;
   assign busy_o           = busy_q;
   assign done_o           = done_q;

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Randomized bench for reg_dump_ctrl with a byte-count based reference model
// and literal pins for the default-parameter dump timing and stream.
module tb_reg_dump_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        halted;
   logic        tx_ready;
   logic [31:0] data_ra;
   logic        sel;
   logic [4:0]  addr;
   logic [7:0]  txd;
   logic        valid;
   logic        busy;
   logic        done;

   logic [31:0] bank [32];
   assign data_ra = bank[addr];

   reg_dump_ctrl dut (
      .clock_i          (clk),
      .reset_i          (rst_n),
      .start_i          (start),
      .halted_i         (halted),
      .data_ra_i        (data_ra),
      .tx_ready_i       (tx_ready),
      .select_debug_o   (sel),
      .addr_reg_debug_o (addr),
      .tx_data_o        (txd),
      .tx_valid_o       (valid),
      .busy_o           (busy),
      .done_o           (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Model: a dump is a sequence of 128 byte slots; a register is latched
   // in the cycle where its first byte is due and has not been latched yet.
   bit          m_act;
   bit          m_done;
   int          m_sent;
   int          m_lat;
   logic [7:0]  got [$];
   int          starts [$];
   int          dones [$];
   int          sizes [$];
   int          cyc = 0;
   int          busy_cnt = 0;
   int          done_cnt = 0;
   bit          pv;
   bit          pr;
   logic [7:0]  pdata;

   task automatic chk(input string nm, input logic [63:0] a,
                      input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, a, e, cyc);
      end
   endtask

   function automatic logic [7:0] byte_of(input int n);
      logic [31:0] w;
      w = bank[n / 4];
      return w[8 * (3 - (n % 4)) +: 8];
   endfunction

   task automatic compare();
      bit latch, ev;
      latch = m_act && (m_lat != m_sent / 4);
      ev    = m_act && !latch;
      chk("busy", busy, m_act || m_done);
      chk("done", done, m_done);
      chk("select", sel, m_act);
      chk("valid", valid, ev);
      if (m_act) chk("addr", addr, m_sent / 4);
      if (ev) chk("data", txd, byte_of(m_sent));
      if (pv && !pr && ev) chk("hold", txd, pdata);
      if (busy) busy_cnt++;
      if (done) done_cnt++;
   endtask

   task automatic model_adv();
      bit latch;
      pv    = valid;
      pr    = tx_ready;
      pdata = txd;
      if (m_done) begin
         m_done = 0;
      end else if (!m_act) begin
         if (start && halted) begin
            m_act  = 1;
            m_sent = 0;
            m_lat  = -1;
            got.delete();
            starts.push_back(cyc);
         end
      end else begin
         latch = (m_lat != m_sent / 4);
         if (!latch && tx_ready) begin
            got.push_back(txd);
            m_sent++;
         end
         if (!halted) begin
            m_act = 0;
         end else if (latch) begin
            m_lat = m_sent / 4;
         end else if (m_sent == 128) begin
            m_act  = 0;
            m_done = 1;
            dones.push_back(cyc + 1);
            sizes.push_back(got.size());
         end
      end
   endtask

   task automatic cycle(input bit s, input bit h, input bit r);
      compare();
      start    = s;
      halted   = h;
      tx_ready = r;
      model_adv();
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic run(input int maxc, input int rpct, output bit ok);
      ok = 0;
      for (int i = 0; i < maxc; i++) begin
         if (!m_act && !m_done) begin
            ok = 1;
            break;
         end
         cycle(0, 1, $urandom_range(0, 99) < rpct);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_sel"}, sel, 0);
      chk({tag, "_addr"}, addr, 0);
      chk({tag, "_data"}, txd, 0);
      chk({tag, "_valid"}, valid, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
   endtask

   task automatic rand_bank();
      for (int k = 0; k < 32; k++) bank[k] = $urandom;
   endtask

   initial begin
      bit ok;
      int dc0, ns, nd;
      logic [31:0] w;
      rst_n    = 1'b0;
      start    = 1'b0;
      halted   = 1'b0;
      tx_ready = 1'b0;
      m_act    = 0;
      m_done   = 0;
      m_sent   = 0;
      m_lat    = -1;
      pv       = 0;
      pr       = 0;
      pdata    = '0;
      for (int k = 0; k < 32; k++) bank[k] = 32'h1000_0000 + k;
      @(negedge clk);
      @(negedge clk);
      chk_zero("reset");
      rst_n = 1'b1;
      cycle(0, 1, 1);

      // Full dump, ready tied high, known bank pattern
      busy_cnt = 0;
      dc0 = done_cnt;
      cycle(1, 1, 1);
      run(400, 100, ok);
      chk("t1_finish", ok, 1);
      for (int i = 0; i < 4; i++) cycle(0, 1, 1);
      chk("t1_bytes", got.size(), 128);
      if (got.size() == 128) begin
         chk("t1_b0", got[0], 8'h10);
         chk("t1_b3", got[3], 8'h00);
         chk("t1_b7", got[7], 8'h01);
         chk("t1_b124", got[124], 8'h10);
         chk("t1_b127", got[127], 8'h1F);
      end
      chk("t1_done_cycle", dones[$] - starts[$], 161);
      chk("t1_busy_cycles", busy_cnt, 161);
      chk("t1_done_pulses", done_cnt - dc0, 1);

      // Backpressure, ready 30% high
      rand_bank();
      cycle(1, 1, $urandom_range(0, 99) < 30);
      run(3000, 30, ok);
      chk("t2_finish", ok, 1);
      chk("t2_bytes", got.size(), 128);
      w = bank[0];
      if (got.size() > 0) chk("t2_first", got[0], w[31:24]);
      w = bank[31];
      if (got.size() == 128) chk("t2_last", got[127], w[7:0]);

      // Start while not halted
      ns = starts.size();
      for (int i = 0; i < 20; i++) cycle(1, 0, 1);
      chk("t3_no_start", starts.size(), ns);
      chk("t3_sel", sel, 0);

      // Abort after the 10th accepted byte
      rand_bank();
      dc0 = done_cnt;
      cycle(1, 1, 1);
      for (int i = 0; i < 200; i++) begin
         if (got.size() >= 10) break;
         cycle(0, 1, 1);
      end
      cycle(0, 0, 0);
      chk("t4_valid_drop", valid, 0);
      chk("t4_busy_drop", busy, 0);
      for (int i = 0; i < 3; i++) cycle(0, 0, 1);
      chk("t4_bytes", got.size(), 10);
      chk("t4_no_done", done_cnt, dc0);
      cycle(1, 1, 1);
      run(400, 100, ok);
      chk("t4_restart_finish", ok, 1);
      chk("t4_restart_bytes", got.size(), 128);
      w = bank[0];
      if (got.size() > 0) chk("t4_restart_first", got[0], w[31:24]);
      chk("t4_restart_done", done_cnt, dc0 + 1);

      // Reset during SEND of register 5
      dc0 = done_cnt;
      cycle(1, 1, 1);
      for (int i = 0; i < 400; i++) begin
         if (m_act && m_lat == 5 && m_sent / 4 == 5) break;
         cycle(0, 1, 1);
      end
      chk("t5_reached", {valid, addr}, {1'b1, 5'd5});
      #2 rst_n = 1'b0;
      #1 chk_zero("t5_async");
      m_act  = 0;
      m_done = 0;
      pv     = 0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      ns = starts.size();
      for (int i = 0; i < 10; i++) cycle(0, 1, 1);
      chk("t5_no_done", done_cnt, dc0);
      chk("t5_no_start", starts.size(), ns);

      // Start held high: back-to-back dumps
      rand_bank();
      ns = starts.size();
      nd = dones.size();
      for (int i = 0; i < 340; i++) cycle(1, 1, 1);
      run(400, 100, ok);
      chk("t6_finish", ok, 1);
      if (starts.size() >= ns + 2 && dones.size() >= nd + 2) begin
         chk("t6_gap", starts[ns + 1] - dones[nd], 1);
         chk("t6_size0", sizes[nd], 128);
         chk("t6_size1", sizes[nd + 1], 128);
         chk("t6_span", dones[nd + 1] - starts[ns + 1], 161);
      end else begin
         chk("t6_dumps", dones.size() - nd, 2);
      end

      // Random mix of start, halted and ready
      rand_bank();
      for (int i = 0; i < 600; i++)
         cycle($urandom_range(0, 9) == 0, $urandom_range(0, 19) != 0,
               $urandom_range(0, 1) == 1);
      run(3000, 50, ok);
      chk("t7_finish", ok, 1);
      cycle(0, 1, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
